// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
//   E-stage issue and stall controller in front of the multiply/divide unit.
//   Accepts HI/LO-class requests, registers their operands, drives the unit's
//   start/op/write-enable/select inputs, tracks operation latency with a local
//   counter and freezes the D stage while a HI/LO-class instruction there
//   cannot safely proceed.
//
//   Optional feature: define MD_DIV0_GUARD_EN to suppress div/divu with a
//   zero divisor and report it on the sticky div0_flag output.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   e_valid      E stage holds a HI/LO-class instruction
//   e_op         0 mult 1 multu 2 div 3 divu 4 mthi 5 mtlo 6 mfhi 7 mflo
//   e_rs, e_rt   forwarded operands
//   flush        kill the E-stage instruction this cycle
//   d_is_md      D-stage instruction is HI/LO-class
//   md_busy      busy flag from the multiply/divide unit
//   md_start     one-cycle start pulse to the unit
//   md_aluop     unit op code, valid with md_start
//   md_rs, md_rt registered operands
//   md_hilowe    one-cycle HI/LO write pulse (mthi/mtlo)
//   md_hilo_a3   0 writes HI, 1 writes LO
//   hi_sel       E-stage result mux select, 1 = HI (mfhi)
//   stall_d      freeze D stage
//   protocol_err sticky: request arrived while an operation was in flight
//   div0_flag    sticky: zero-divisor divide suppressed (MD_DIV0_GUARD_EN only)

module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter logic [5:0]  OP_MUL  = 6'd1,
    parameter logic [5:0]  OP_MULU = 6'd2,
    parameter logic [5:0]  OP_DIV  = 6'd3,
    parameter logic [5:0]  OP_DIVU = 6'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        d_is_md,
    input  logic        md_busy,
    output logic        md_start,
    output logic [5:0]  md_aluop,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt,
    output logic        md_hilowe,
    output logic        md_hilo_a3,
    output logic        hi_sel,
    output logic        stall_d,
    output logic        protocol_err
`ifdef MD_DIV0_GUARD_EN
   ,output logic        div0_flag
`endif
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MOVE  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             req;
    logic             accept;
    logic             is_muldiv;
    logic             is_div;
    logic             is_mt;
    logic             div0_sup;
    logic             start_issue;
    logic             start_move;
    logic [5:0]       op_code;
    logic [CNT_W-1:0] lat_sel;

    always_comb begin
        req       = e_valid && !flush;
        accept    = req && (state == IDLE);
        is_muldiv = !e_op[2];
        is_div    = (e_op[2:1] == 2'b01);
        is_mt     = (e_op[2:1] == 2'b10);
`ifdef MD_DIV0_GUARD_EN
        div0_sup  = is_div && (e_rt == '0);
`else
        div0_sup  = 1'b0;
`endif
        start_issue = accept && is_muldiv && !div0_sup;
        start_move  = accept && is_mt;

        case (e_op[1:0])
            2'd0:    op_code = OP_MUL;
            2'd1:    op_code = OP_MULU;
            2'd2:    op_code = OP_DIV;
            default: op_code = OP_DIVU;
        endcase

        lat_sel = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

        // Gated by reset so every output reads 0 while reset is asserted.
        stall_d = reset && d_is_md &&
                  ((state != IDLE) || start_issue || start_move || md_busy);
        hi_sel  = reset && (e_op == 3'd6);
    end

    // The counter is loaded on acceptance so it already holds the full
    // latency during ISSUE; RUN exits at 1, landing IDLE in the write cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            md_start     <= 1'b0;
            md_aluop     <= '0;
            md_rs        <= '0;
            md_rt        <= '0;
            md_hilowe    <= 1'b0;
            md_hilo_a3   <= 1'b0;
            protocol_err <= 1'b0;
`ifdef MD_DIV0_GUARD_EN
            div0_flag    <= 1'b0;
`endif
        end else begin
            md_start  <= 1'b0;
            md_hilowe <= 1'b0;

            if (req && (state != IDLE)) begin
                protocol_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_issue) begin
                        state    <= ISSUE;
                        cnt      <= lat_sel;
                        md_start <= 1'b1;
                        md_aluop <= op_code;
                        md_rs    <= e_rs;
                        md_rt    <= e_rt;
                    end else if (start_move) begin
                        state      <= MOVE;
                        md_hilowe  <= 1'b1;
                        md_hilo_a3 <= e_op[0];
                        md_rs      <= e_rs;
                        md_rt      <= e_rt;
                    end
`ifdef MD_DIV0_GUARD_EN
                    if (accept && div0_sup) begin
                        div0_flag <= 1'b1;
                    end
`endif
                end
                ISSUE, RUN: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        state <= RUN;
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                MOVE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios followed by a
// randomized run against a cycle-window reference model.
module tb_md_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        flush;
    logic        d_is_md;
    logic        md_busy;
    logic        md_start;
    logic [5:0]  md_aluop;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        md_hilowe;
    logic        md_hilo_a3;
    logic        hi_sel;
    logic        stall_d;
    logic        protocol_err;
`ifdef MD_DIV0_GUARD_EN
    logic        div0_flag;
`endif

    int checks = 0;
    int errors = 0;

    md_issue_ctrl #(
        .MUL_LAT(5),
        .DIV_LAT(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .e_valid(e_valid),
        .e_op(e_op),
        .e_rs(e_rs),
        .e_rt(e_rt),
        .flush(flush),
        .d_is_md(d_is_md),
        .md_busy(md_busy),
        .md_start(md_start),
        .md_aluop(md_aluop),
        .md_rs(md_rs),
        .md_rt(md_rt),
        .md_hilowe(md_hilowe),
        .md_hilo_a3(md_hilo_a3),
        .hi_sel(hi_sel),
        .stall_d(stall_d),
        .protocol_err(protocol_err)
`ifdef MD_DIV0_GUARD_EN
       ,.div0_flag(div0_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge of the same cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        e_valid = 1'b0;
        e_op    = 3'd0;
        e_rs    = '0;
        e_rt    = '0;
        flush   = 1'b0;
        d_is_md = 1'b0;
        md_busy = 1'b0;
    endtask

    task automatic test_reset();
        logic [75:0] outs;
        quiet_inputs();
        reset   = 1'b0;
        d_is_md = 1'b1;
        md_busy = 1'b1;
        e_op    = 3'd6;
        sample();
        checks++;
        outs = {md_start, md_aluop, md_rs, md_rt, md_hilowe, md_hilo_a3, hi_sel, stall_d, protocol_err};
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        step();
        reset = 1'b1;
        quiet_inputs();
        // div in flight, then reset mid-RUN
        e_valid = 1'b1; e_op = 3'd2; e_rs = 32'd50; e_rt = 32'd5;
        step();
        quiet_inputs();
        d_is_md = 1'b1;
        step();
        step();
        sample();
        checks++;
        if (stall_d !== 1'b1) begin
            errors++;
            $display("FAIL run_stall_before_reset got %b want 1", stall_d);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        outs = {md_start, md_aluop, md_rs, md_rt, md_hilowe, md_hilo_a3, hi_sel, stall_d, protocol_err};
        if (outs !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got %h want 0", outs);
        end
        step();
        reset = 1'b1;
        quiet_inputs();
        e_valid = 1'b1; e_op = 3'd0; e_rs = 32'd3; e_rt = 32'hFFFF_FFFE;
        sample();
        checks++;
        if (md_start !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_accept_start got %b want 0", md_start);
        end
        step();
        quiet_inputs();
        sample();
        checks++;
        if ({md_start, md_aluop, md_rs, md_rt, protocol_err} !== {1'b1, 6'd1, 32'd3, 32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_mult start=%b op=%0d rs=%h rt=%h perr=%b want 1 1 00000003 fffffffe 0",
                     md_start, md_aluop, md_rs, md_rt, protocol_err);
        end
        repeat (6) step();
    endtask

    task automatic test_mult_timing();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        quiet_inputs();
        d_is_md = 1'b1;
        e_valid = 1'b1; e_op = 3'd0; e_rs = a; e_rt = b;
        for (int k = 0; k < 8; k++) begin
            sample();
            checks++;
            if (md_start !== (k == 1)) begin
                errors++;
                $display("FAIL mult_start k=%0d got %b want %b", k, md_start, (k == 1));
            end
            checks++;
            if (stall_d !== (k <= 5)) begin
                errors++;
                $display("FAIL mult_stall k=%0d got %b want %b", k, stall_d, (k <= 5));
            end
            if (k == 1) begin
                checks++;
                if ({md_aluop, md_rs, md_rt} !== {6'd1, a, b}) begin
                    errors++;
                    $display("FAIL mult_operands op=%0d rs=%h rt=%h want 1 %h %h", md_aluop, md_rs, md_rt, a, b);
                end
            end
            step();
            e_valid = 1'b0;
        end
    endtask

    task automatic test_divu_stall();
        quiet_inputs();
        d_is_md = 1'b1;
        e_valid = 1'b1; e_op = 3'd3; e_rs = 32'd100; e_rt = 32'd7;
        for (int k = 0; k < 13; k++) begin
            sample();
            checks++;
            if (md_start !== (k == 1)) begin
                errors++;
                $display("FAIL divu_start k=%0d got %b want %b", k, md_start, (k == 1));
            end
            checks++;
            if (stall_d !== (k <= 10)) begin
                errors++;
                $display("FAIL divu_stall k=%0d got %b want %b", k, stall_d, (k <= 10));
            end
            if (k == 1) begin
                checks++;
                if ({md_aluop, md_rs, md_rt} !== {6'd4, 32'd100, 32'd7}) begin
                    errors++;
                    $display("FAIL divu_operands op=%0d rs=%0d rt=%0d want 4 100 7", md_aluop, md_rs, md_rt);
                end
            end
            step();
            e_valid = 1'b0;
        end
    endtask

    task automatic test_move();
        logic [31:0] vals [2];
        vals[0] = 32'hDEAD_BEEF;
        vals[1] = 32'h1234_5678;
        for (int m = 0; m < 2; m++) begin
            quiet_inputs();
            d_is_md = 1'b1;
            e_valid = 1'b1; e_op = (m == 0) ? 3'd5 : 3'd4; e_rs = vals[m];
            sample();
            checks++;
            if (stall_d !== 1'b1) begin
                errors++;
                $display("FAIL move_accept_stall m=%0d got %b want 1", m, stall_d);
            end
            step();
            e_valid = 1'b0;
            sample();
            checks++;
            if ({md_hilowe, md_hilo_a3, md_rs, md_start} !== {1'b1, (m == 0), vals[m], 1'b0}) begin
                errors++;
                $display("FAIL move_pulse m=%0d we=%b a3=%b rs=%h start=%b want 1 %b %h 0",
                         m, md_hilowe, md_hilo_a3, md_rs, md_start, (m == 0), vals[m]);
            end
            step();
            sample();
            checks++;
            if ({md_hilowe, stall_d} !== 2'b00) begin
                errors++;
                $display("FAIL move_done m=%0d we=%b stall=%b want 0 0", m, md_hilowe, stall_d);
            end
            step();
        end
    endtask

    task automatic test_flush_protocol();
        quiet_inputs();
        e_valid = 1'b1; e_op = 3'd2; e_rs = 32'd8; e_rt = 32'd2; flush = 1'b1;
        sample();
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_dmd0 got %b want 0", stall_d);
        end
        #1 d_is_md = 1'b1;
        #1;
        checks++;
        if (stall_d !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_dmd1 got %b want 0", stall_d);
        end
        step();
        quiet_inputs();
        sample();
        checks++;
        if ({md_start, protocol_err} !== 2'b00) begin
            errors++;
            $display("FAIL flush_drop start=%b perr=%b want 0 0", md_start, protocol_err);
        end
        step();
        // mult; flushed request during RUN, then an illegal request
        e_valid = 1'b1; e_op = 3'd0; e_rs = 32'd6; e_rt = 32'd7; d_is_md = 1'b1;
        step();
        e_valid = 1'b0;
        step();
        e_valid = 1'b1; e_op = 3'd3; flush = 1'b1;
        step();
        flush = 1'b0; e_op = 3'd1;
        sample();
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_before_set got %b want 0", protocol_err);
        end
        step();
        e_valid = 1'b0;
        sample();
        checks++;
        if ({protocol_err, md_start, stall_d} !== 3'b101) begin
            errors++;
            $display("FAIL perr_set perr=%b start=%b stall=%b want 1 0 1", protocol_err, md_start, stall_d);
        end
        step();
        sample();
        checks++;
        if (stall_d !== 1'b1) begin
            errors++;
            $display("FAIL perr_run_k5 stall=%b want 1", stall_d);
        end
        step();
        sample();
        checks++;
        if ({stall_d, protocol_err} !== 2'b01) begin
            errors++;
            $display("FAIL perr_complete stall=%b perr=%b want 0 1", stall_d, protocol_err);
        end
        step();
    endtask

    task automatic test_div_zero();
        quiet_inputs();
        e_valid = 1'b1; e_op = 3'd2; e_rs = 32'd9; e_rt = 32'd0;
        step();
        e_valid = 1'b0;
        sample();
        checks++;
`ifdef MD_DIV0_GUARD_EN
        if ({md_start, div0_flag} !== 2'b01) begin
            errors++;
            $display("FAIL div0_guard start=%b flag=%b want 0 1", md_start, div0_flag);
        end
`else
        if (md_start !== 1'b1) begin
            errors++;
            $display("FAIL div0_issue start=%b want 1", md_start);
        end
`endif
        repeat (12) step();
    endtask

    task automatic test_random();
        int          free_at, start_cyc, move_cyc;
        bit          perr, d0, idle, req, sup, long_acc, exp_stall;
        logic [5:0]  s_op;
        logic [31:0] s_rs, s_rt;
        bit          s_a3;
        quiet_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        free_at = 0; start_cyc = -1; move_cyc = -1;
        perr = 0; d0 = 0; s_op = '0; s_rs = '0; s_rt = '0; s_a3 = 0;
        for (int c = 0; c < 400; c++) begin
            e_valid = ($urandom_range(0, 99) < 35);
            flush   = ($urandom_range(0, 99) < 15);
            e_op    = 3'($urandom_range(0, 7));
            e_rs    = $urandom;
            e_rt    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            d_is_md = 1'($urandom_range(0, 1));
            md_busy = ($urandom_range(0, 9) == 0);
            sample();
            idle = (c >= free_at);
            req  = e_valid && !flush;
`ifdef MD_DIV0_GUARD_EN
            sup  = (e_op == 3'd2 || e_op == 3'd3) && (e_rt == 32'd0);
`else
            sup  = 0;
`endif
            long_acc  = req && idle && (e_op <= 3'd5) && !sup;
            exp_stall = d_is_md && (!idle || long_acc || md_busy);
            checks++;
            if (stall_d !== exp_stall) begin
                errors++;
                $display("FAIL rnd_stall c=%0d got %b want %b", c, stall_d, exp_stall);
            end
            checks++;
            if (hi_sel !== (e_op == 3'd6)) begin
                errors++;
                $display("FAIL rnd_hi_sel c=%0d got %b want %b", c, hi_sel, (e_op == 3'd6));
            end
            checks++;
            if (md_start !== (c == start_cyc)) begin
                errors++;
                $display("FAIL rnd_start c=%0d got %b want %b", c, md_start, (c == start_cyc));
            end
            if (c == start_cyc) begin
                checks++;
                if ({md_aluop, md_rs, md_rt} !== {s_op, s_rs, s_rt}) begin
                    errors++;
                    $display("FAIL rnd_issue c=%0d op=%0d rs=%h rt=%h want %0d %h %h",
                             c, md_aluop, md_rs, md_rt, s_op, s_rs, s_rt);
                end
            end
            checks++;
            if (md_hilowe !== (c == move_cyc)) begin
                errors++;
                $display("FAIL rnd_hilowe c=%0d got %b want %b", c, md_hilowe, (c == move_cyc));
            end
            if (c == move_cyc) begin
                checks++;
                if ({md_hilo_a3, md_rs} !== {s_a3, s_rs}) begin
                    errors++;
                    $display("FAIL rnd_move c=%0d a3=%b rs=%h want %b %h", c, md_hilo_a3, md_rs, s_a3, s_rs);
                end
            end
            checks++;
            if (protocol_err !== perr) begin
                errors++;
                $display("FAIL rnd_perr c=%0d got %b want %b", c, protocol_err, perr);
            end
`ifdef MD_DIV0_GUARD_EN
            checks++;
            if (div0_flag !== d0) begin
                errors++;
                $display("FAIL rnd_div0 c=%0d got %b want %b", c, div0_flag, d0);
            end
`endif
            // model update for the end of cycle c
            if (req && !idle) begin
                perr = 1;
            end else if (req && idle) begin
                if (e_op <= 3'd3 && !sup) begin
                    start_cyc = c + 1;
                    free_at   = c + 1 + ((e_op <= 3'd1) ? 5 : 10);
                    s_op      = 6'(e_op) + 6'd1;
                    s_rs      = e_rs;
                    s_rt      = e_rt;
                end else if (e_op == 3'd4 || e_op == 3'd5) begin
                    move_cyc = c + 1;
                    free_at  = c + 2;
                    s_a3     = (e_op == 3'd5);
                    s_rs     = e_rs;
                end else if (sup) begin
                    d0 = 1;
                end
            end
            step();
        end
        quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b0;
        test_reset();
        test_mult_timing();
        test_divu_stall();
        test_move();
        test_flush_protocol();
        test_div_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
